// File: rtl/decode_regfile.sv
// decode_regfile -- decode / register-file stage of a multi-cycle MIPS32 datapath.
//
// Holds the instruction register, the memory data register, the 32-entry GPR
// file and the A/B operand latches. Every state element is loaded only when
// the control FSM raises its enable.
//
// Ports
//   clk        rising-edge clock
//   nrst       asynchronous reset, active low; clears every register and GPR
//   mem_rdata  memory read data (instruction word or load data)
//   alu_out    registered ALU result, write-back source for R-type/ALU ops
//   IR, MDR    load enables for the instruction / memory data registers
//   RegA, RegB load enables for the A / B operand latches
//   RegDst     write-address select: 1 = rd, 0 = rt
//   MemtoReg   write-data select: 1 = MDR, 0 = alu_out
//   RegWrite   GPR write enable
//   dbg_addr   debug read address
//   op, func   opcode and function fields, returned to the control FSM
//   rs, rt, rd register fields of the held instruction
//   imm_sext   sign-extended 16-bit immediate
//   reg_a      A operand latch
//   reg_b      B operand latch
//   mdr_q      memory data register contents
//   dbg_data   GPR[dbg_addr], combinational
module decode_regfile #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              IR,
  input  logic              MDR,
  input  logic              RegA,
  input  logic              RegB,
  input  logic              RegDst,
  input  logic              MemtoReg,
  input  logic              RegWrite,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [5:0]        op,
  output logic [5:0]        func,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [DATA_W-1:0] imm_sext,
  output logic [DATA_W-1:0] reg_a,
  output logic [DATA_W-1:0] reg_b,
  output logic [DATA_W-1:0] mdr_q,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int NREG = 2 ** REG_AW;

  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] gpr [NREG];

  logic [REG_AW-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  // Sign-extend the 16-bit immediate field to the datapath width.
  function automatic logic signed [DATA_W-1:0] sext16(input logic signed [15:0] v);
    return {{(DATA_W-16){v[15]}}, v};
  endfunction

  // Register 0 is hard-wired to zero on every read path, so whatever the
  // array slot holds is never observed.
  function automatic logic [DATA_W-1:0] rd_gpr(input logic [REG_AW-1:0] a);
    return (a == '0) ? '0 : gpr[a];
  endfunction

  assign op       = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign func     = ir_q[5:0];
  assign imm_sext = sext16(ir_q[15:0]);
  assign reg_a    = a_q;
  assign reg_b    = b_q;
  assign dbg_data = rd_gpr(dbg_addr);

  // Write data uses the registered MDR, so a same-edge MDR load writes the
  // previous word.
  always_comb begin
    waddr = RegDst ? rd : rt;
    wdata = MemtoReg ? mdr_q : alu_out;
  end

  // Single state boundary: every register samples on the same rising edge.
  // A/B read the pre-edge array, so a same-edge write is not bypassed.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ir_q  <= '0;
      mdr_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      for (int i = 0; i < NREG; i++) gpr[i] <= '0;
    end else begin
      if (IR)   ir_q  <= mem_rdata;
      if (MDR)  mdr_q <= mem_rdata;
      if (RegA) a_q   <= rd_gpr(rs);
      if (RegB) b_q   <= rd_gpr(rt);
      if (RegWrite && (waddr != '0)) gpr[waddr] <= wdata;
    end
  end

endmodule
